// File: rtl/board_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// board_mem_arbiter_pkg
// Board geometry, BRAM word/address widths, the board coordinate type, the BRAM
// owner tags and the helpers that map a board cell onto a word address and a
// bit index. Imported by the arbiter and its cell editor.
// -----------------------------------------------------------------------------
package board_mem_arbiter_pkg;

  localparam int WORD_SIZE      = 32;
  localparam int LOG_WORD_SIZE  = 5;
  localparam int BOARD_SIZE     = 64;
  localparam int LOG_BOARD_SIZE = 6;
  // BOARD_SIZE*BOARD_SIZE/WORD_SIZE = 128 words
  localparam int LOG_MAX_ADDR   = 7;

  typedef struct packed {
    logic [LOG_BOARD_SIZE-1:0] x;
    logic [LOG_BOARD_SIZE-1:0] y;
  } pos_t;

  // Who owns the read currently travelling through the BRAM latency.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_RND,
    OWN_ENG,
    OWN_EDIT
  } mem_owner_t;

  typedef enum logic [1:0] {
    ED_IDLE,
    ED_RD_REQ,
    ED_RD_WAIT,
    ED_WR_REQ
  } edit_state_t;

  // Round-robin pointer between the engine and the editor.
  typedef enum logic {
    RR_ENG,
    RR_EDIT
  } rr_ptr_t;

  // Word holding cell (x, y); truncated to the BRAM address width.
  function automatic logic [LOG_MAX_ADDR-1:0] cell_word_addr(
    input logic [LOG_BOARD_SIZE-1:0] x,
    input logic [LOG_BOARD_SIZE-1:0] y,
    input int                        words_per_row
  );
    logic [31:0] w_full;
    w_full = 32'(y) * 32'(words_per_row) + 32'(x >> LOG_WORD_SIZE);
    return w_full[LOG_MAX_ADDR-1:0];
  endfunction

  // Cells are packed MSB-first: x offset 0 lives in bit WORD_SIZE-1.
  function automatic logic [LOG_WORD_SIZE-1:0] cell_bit_index(
    input logic [LOG_BOARD_SIZE-1:0] x
  );
    return LOG_WORD_SIZE'(WORD_SIZE - 1) - x[LOG_WORD_SIZE-1:0];
  endfunction

endpackage

// File: rtl/board_mem_arbiter_cell_toggle_fsm.sv
// -----------------------------------------------------------------------------
// cell_toggle_fsm
// Read-modify-write editor that inverts one board cell. A toggle pulse latches
// the word address and bit index, the editor reads the word, flips the bit and
// writes it back. lock_out spans from the read grant to the write grant so the
// arbiter can keep the engine away from the word being edited.
//
// Ports:
//   clk_130mhz, rst_n  clock, asynchronous active-low reset
//   toggle_in          one-cycle pulse, ignored while busy
//   pos_in             cell to toggle
//   gnt_in             arbiter accepted this cycle's req_out
//   valid_in           editor read data valid (EDIT tag emerged)
//   rd_data_in         shared read data bus
//   req_out/we_out     access request and its direction
//   addr_out/data_out  access address and write data
//   lock_out           RMW owns the word; engine must not be granted
//   busy_out           RMW in progress
// -----------------------------------------------------------------------------
module cell_toggle_fsm
  import board_mem_arbiter_pkg::*;
#(
  parameter int WORDS_PER_ROW = BOARD_SIZE / WORD_SIZE
) (
  input  logic                    clk_130mhz,
  input  logic                    rst_n,
  input  logic                    toggle_in,
  input  pos_t                    pos_in,
  input  logic                    gnt_in,
  input  logic                    valid_in,
  input  logic [WORD_SIZE-1:0]    rd_data_in,
  output logic                    req_out,
  output logic                    we_out,
  output logic [LOG_MAX_ADDR-1:0] addr_out,
  output logic [WORD_SIZE-1:0]    data_out,
  output logic                    lock_out,
  output logic                    busy_out
);

  edit_state_t               r_state;
  edit_state_t               w_state_next;
  logic [LOG_MAX_ADDR-1:0]   r_addr;
  logic [LOG_MAX_ADDR-1:0]   w_addr_next;
  logic [LOG_WORD_SIZE-1:0]  r_bit;
  logic [LOG_WORD_SIZE-1:0]  w_bit_next;
  logic [WORD_SIZE-1:0]      r_word;
  logic [WORD_SIZE-1:0]      w_word_next;

  always_ff @(posedge clk_130mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ED_IDLE;
      r_addr  <= '0;
      r_bit   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_bit   <= w_bit_next;
      r_word  <= w_word_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_bit_next   = r_bit;
    w_word_next  = r_word;
    req_out      = 1'b0;
    we_out       = 1'b0;
    lock_out     = 1'b0;
    busy_out     = 1'b1;
    case (r_state)
      ED_IDLE: begin
        busy_out = 1'b0;
        if (toggle_in) begin
          w_addr_next  = cell_word_addr(pos_in.x, pos_in.y, WORDS_PER_ROW);
          w_bit_next   = cell_bit_index(pos_in.x);
          w_state_next = ED_RD_REQ;
        end
      end
      ED_RD_REQ: begin
        req_out = 1'b1;
        if (gnt_in) begin
          w_state_next = ED_RD_WAIT;
        end
      end
      ED_RD_WAIT: begin
        lock_out = 1'b1;
        if (valid_in) begin
          w_word_next  = rd_data_in ^ (WORD_SIZE'(1) << r_bit);
          w_state_next = ED_WR_REQ;
        end
      end
      ED_WR_REQ: begin
        req_out  = 1'b1;
        we_out   = 1'b1;
        lock_out = 1'b1;
        if (gnt_in) begin
          w_state_next = ED_IDLE;
        end
      end
      default: begin
        w_state_next = ED_IDLE;
      end
    endcase
  end

  assign addr_out = r_addr;
  assign data_out = r_word;

endmodule

// File: rtl/board_mem_arbiter.sv
// -----------------------------------------------------------------------------
// board_mem_arbiter
// Owns the single BRAM port and shares it between the renderer (read-only,
// absolute priority), the life engine (read/write) and the internal cursor
// cell editor. The winning access is registered onto mem_*_out; a tag pipe of
// depth MEM_LATENCY+1 follows each read so the data returning from the BRAM is
// strobed to its owner exactly once.
//
// Ports:
//   clk_130mhz, rst_n          clock, asynchronous active-low reset
//   rnd_req_in/rnd_addr_in     renderer read, never stalled
//   rnd_valid_out              renderer data strobe
//   eng_req_in/eng_we_in/eng_addr_in/eng_data_in  engine access
//   eng_gnt_out                engine grant (combinational)
//   eng_valid_out              engine read data strobe
//   rd_data_out                shared read data, qualified by the strobes
//   edit_toggle_in/edit_x_in/edit_y_in  toggle one board cell
//   edit_busy_out              editor RMW in progress
//   mem_addr_out/mem_we_out/mem_din_out  registered BRAM controls
//   mem_dout_in                BRAM read data
// -----------------------------------------------------------------------------
module board_mem_arbiter
  import board_mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY   = 2,
  parameter int WORDS_PER_ROW = BOARD_SIZE / WORD_SIZE
) (
  input  logic                      clk_130mhz,
  input  logic                      rst_n,
  input  logic                      rnd_req_in,
  input  logic [LOG_MAX_ADDR-1:0]   rnd_addr_in,
  output logic                      rnd_valid_out,
  input  logic                      eng_req_in,
  input  logic                      eng_we_in,
  input  logic [LOG_MAX_ADDR-1:0]   eng_addr_in,
  input  logic [WORD_SIZE-1:0]      eng_data_in,
  output logic                      eng_gnt_out,
  output logic                      eng_valid_out,
  output logic [WORD_SIZE-1:0]      rd_data_out,
  input  logic                      edit_toggle_in,
  input  logic [LOG_BOARD_SIZE-1:0] edit_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] edit_y_in,
  output logic                      edit_busy_out,
  output logic [LOG_MAX_ADDR-1:0]   mem_addr_out,
  output logic                      mem_we_out,
  output logic [WORD_SIZE-1:0]      mem_din_out,
  input  logic [WORD_SIZE-1:0]      mem_dout_in
);

  localparam int TAG_DEPTH = MEM_LATENCY + 1;

  // r_run keeps the engine grant low while reset is asserted and for the
  // first edge after release, so every output reads 0 in reset.
  logic                    r_run;
  rr_ptr_t                 r_rr;
  rr_ptr_t                 w_rr_next;
  logic [LOG_MAX_ADDR-1:0] r_mem_addr;
  logic [LOG_MAX_ADDR-1:0] w_addr_next;
  logic                    r_mem_we;
  logic                    w_we_next;
  logic [WORD_SIZE-1:0]    r_mem_din;
  logic [WORD_SIZE-1:0]    w_din_next;
  mem_owner_t              w_tag_next;
  mem_owner_t              w_tag_out;

  pos_t                    w_edit_pos;
  logic                    w_edit_req;
  logic                    w_edit_we;
  logic [LOG_MAX_ADDR-1:0] w_edit_addr;
  logic [WORD_SIZE-1:0]    w_edit_data;
  logic                    w_edit_lock;
  logic                    w_edit_gnt;
  logic                    w_edit_valid;
  logic                    w_edit_wins_rr;
  logic                    w_eng_xfer;

  assign w_edit_pos = '{x: edit_x_in, y: edit_y_in};

  cell_toggle_fsm #(
    .WORDS_PER_ROW (WORDS_PER_ROW)
  ) u_editor (
    .clk_130mhz (clk_130mhz),
    .rst_n      (rst_n),
    .toggle_in  (edit_toggle_in),
    .pos_in     (w_edit_pos),
    .gnt_in     (w_edit_gnt),
    .valid_in   (w_edit_valid),
    .rd_data_in (rd_data_out),
    .req_out    (w_edit_req),
    .we_out     (w_edit_we),
    .addr_out   (w_edit_addr),
    .data_out   (w_edit_data),
    .lock_out   (w_edit_lock),
    .busy_out   (edit_busy_out)
  );

  // The editor wins round-robin when it is its turn or the engine is quiet.
  assign w_edit_wins_rr = w_edit_req && ((r_rr == RR_EDIT) || !eng_req_in);
  // While locked the editor's pending write beats the engine regardless of
  // the pointer; the engine is also shut out while the read is in flight.
  assign w_edit_gnt  = r_run && !rnd_req_in && w_edit_req && (w_edit_lock || w_edit_wins_rr);
  assign eng_gnt_out = r_run && !rnd_req_in && !w_edit_lock && !w_edit_wins_rr;
  assign w_eng_xfer  = eng_req_in && eng_gnt_out;

  always_comb begin
    w_addr_next = r_mem_addr;
    w_din_next  = r_mem_din;
    w_we_next   = 1'b0;
    w_tag_next  = OWN_NONE;
    w_rr_next   = r_rr;
    if (rnd_req_in) begin
      w_addr_next = rnd_addr_in;
      w_tag_next  = OWN_RND;
    end else if (w_edit_gnt) begin
      w_addr_next = w_edit_addr;
      w_we_next   = w_edit_we;
      w_din_next  = w_edit_data;
      w_tag_next  = w_edit_we ? OWN_NONE : OWN_EDIT;
      w_rr_next   = RR_ENG;
    end else if (w_eng_xfer) begin
      w_addr_next = eng_addr_in;
      w_we_next   = eng_we_in;
      w_din_next  = eng_data_in;
      w_tag_next  = eng_we_in ? OWN_NONE : OWN_ENG;
      w_rr_next   = RR_EDIT;
    end
  end

  always_ff @(posedge clk_130mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_rr       <= RR_ENG;
      r_mem_addr <= '0;
      r_mem_we   <= 1'b0;
      r_mem_din  <= '0;
    end else begin
      r_run      <= 1'b1;
      r_rr       <= w_rr_next;
      r_mem_addr <= w_addr_next;
      r_mem_we   <= w_we_next;
      r_mem_din  <= w_din_next;
    end
  end

  // Owner tag pipe: stage 0 lines up with the registered address, the last
  // stage with the cycle the BRAM presents that address's data.
  genvar gi;
  generate
    for (gi = 0; gi < TAG_DEPTH; gi++) begin : g_tag
      mem_owner_t r_stage;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk_130mhz or negedge rst_n) begin
          if (!rst_n) r_stage <= OWN_NONE;
          else        r_stage <= w_tag_next;
        end
      end else begin : g_body
        always_ff @(posedge clk_130mhz or negedge rst_n) begin
          if (!rst_n) r_stage <= OWN_NONE;
          else        r_stage <= g_tag[gi-1].r_stage;
        end
      end
    end
  endgenerate

  assign w_tag_out     = g_tag[TAG_DEPTH-1].r_stage;
  assign rnd_valid_out = (w_tag_out == OWN_RND);
  assign eng_valid_out = (w_tag_out == OWN_ENG);
  assign w_edit_valid  = (w_tag_out == OWN_EDIT);
  assign rd_data_out   = (w_tag_out != OWN_NONE) ? mem_dout_in : '0;

  assign mem_addr_out = r_mem_addr;
  assign mem_we_out   = r_mem_we;
  assign mem_din_out  = r_mem_din;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_board_mem_arbiter
// Drives the arbiter against a 2-cycle BRAM model. A transaction-level model
// (shadow memory + queue of expected read returns) predicts every valid strobe
// and every returned word; directed sections cover the renderer stream, engine
// read/write, editor toggles, contention, ignored toggles and mid-RMW reset,
// followed by a randomized mix and a final memory comparison.
// -----------------------------------------------------------------------------
module tb_board_mem_arbiter;
  import board_mem_arbiter_pkg::*;

  localparam int NWORDS = 1 << LOG_MAX_ADDR;
  localparam int WPR    = BOARD_SIZE / WORD_SIZE;
  localparam int RD_LAT = 3;  // accept cycle -> data cycle (1 + BRAM latency)

  logic                      clk_130mhz = 1'b0;
  logic                      rst_n;
  logic                      rnd_req_in = 1'b0;
  logic [LOG_MAX_ADDR-1:0]   rnd_addr_in = '0;
  logic                      rnd_valid_out;
  logic                      eng_req_in = 1'b0;
  logic                      eng_we_in = 1'b0;
  logic [LOG_MAX_ADDR-1:0]   eng_addr_in = '0;
  logic [WORD_SIZE-1:0]      eng_data_in = '0;
  logic                      eng_gnt_out;
  logic                      eng_valid_out;
  logic [WORD_SIZE-1:0]      rd_data_out;
  logic                      edit_toggle_in = 1'b0;
  logic [LOG_BOARD_SIZE-1:0] edit_x_in = '0;
  logic [LOG_BOARD_SIZE-1:0] edit_y_in = '0;
  logic                      edit_busy_out;
  logic [LOG_MAX_ADDR-1:0]   mem_addr_out;
  logic                      mem_we_out;
  logic [WORD_SIZE-1:0]      mem_din_out;
  logic [WORD_SIZE-1:0]      mem_dout_in;

  always #5 clk_130mhz = ~clk_130mhz;

  board_mem_arbiter #(.MEM_LATENCY(2)) dut (
    .clk_130mhz     (clk_130mhz),
    .rst_n          (rst_n),
    .rnd_req_in     (rnd_req_in),
    .rnd_addr_in    (rnd_addr_in),
    .rnd_valid_out  (rnd_valid_out),
    .eng_req_in     (eng_req_in),
    .eng_we_in      (eng_we_in),
    .eng_addr_in    (eng_addr_in),
    .eng_data_in    (eng_data_in),
    .eng_gnt_out    (eng_gnt_out),
    .eng_valid_out  (eng_valid_out),
    .rd_data_out    (rd_data_out),
    .edit_toggle_in (edit_toggle_in),
    .edit_x_in      (edit_x_in),
    .edit_y_in      (edit_y_in),
    .edit_busy_out  (edit_busy_out),
    .mem_addr_out   (mem_addr_out),
    .mem_we_out     (mem_we_out),
    .mem_din_out    (mem_din_out),
    .mem_dout_in    (mem_dout_in)
  );

  // ---------------- BRAM model (2-cycle read, preload port) ----------------
  logic [WORD_SIZE-1:0]    mem [NWORDS];
  logic [WORD_SIZE-1:0]    bram_s1;
  logic                    pl_en = 1'b0;
  logic [LOG_MAX_ADDR-1:0] pl_addr = '0;
  logic [WORD_SIZE-1:0]    pl_data = '0;

  always @(posedge clk_130mhz) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_we_out) mem[mem_addr_out] <= mem_din_out;
    bram_s1     <= mem[mem_addr_out];
    mem_dout_in <= bram_s1;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        is_eng;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t                 exp_q[$];
  exp_t                 m_ent;
  logic [WORD_SIZE-1:0] shadow [NWORDS];
  int                   cyc = 0;
  logic                 m_exp_r, m_exp_e;
  logic [31:0]          m_exp_d;
  logic                 prev_busy = 1'b0;
  logic                 edit_pending = 1'b0;
  int                   ed_addr = 0;
  logic [31:0]          ed_mask = '0;
  int                   rvalid_cnt = 0, evalid_cnt = 0, wr_cnt = 0;
  int                   busy_cycles = 0, eng_xfer_cnt = 0, eng_busy_xfer = 0;
  logic [31:0]          last_eng_data = '0;

  always @(negedge clk_130mhz) begin
    if (pl_en) shadow[pl_addr] = pl_data;
    if (!rst_n) begin
      exp_q.delete();
      prev_busy    = 1'b0;
      edit_pending = 1'b0;
    end else begin
      cyc++;
      m_exp_r = 1'b0;
      m_exp_e = 1'b0;
      m_exp_d = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        m_ent = exp_q.pop_front();
        if (m_ent.is_eng) m_exp_e = 1'b1;
        else              m_exp_r = 1'b1;
        m_exp_d = m_ent.data;
      end
      check_eq("rnd_valid", 32'(rnd_valid_out), 32'(m_exp_r));
      check_eq("eng_valid", 32'(eng_valid_out), 32'(m_exp_e));
      if (m_exp_r || m_exp_e) check_eq("rd_data", rd_data_out, m_exp_d);
      if (rnd_req_in) check_eq("eng_gnt_under_rnd", 32'(eng_gnt_out), 32'd0);

      if (rnd_valid_out) rvalid_cnt++;
      if (eng_valid_out) begin
        evalid_cnt++;
        last_eng_data = rd_data_out;
      end
      if (mem_we_out) wr_cnt++;

      // Editor write granted last cycle: the toggle becomes visible now.
      if (prev_busy && !edit_busy_out) begin
        shadow[ed_addr] = shadow[ed_addr] ^ ed_mask;
        edit_pending = 1'b0;
      end
      prev_busy = edit_busy_out;
      if (edit_busy_out) busy_cycles++;
      if (eng_req_in && eng_gnt_out) begin
        eng_xfer_cnt++;
        if (edit_busy_out) eng_busy_xfer++;
      end

      if (edit_toggle_in && !edit_pending) begin
        ed_addr      = (int'(edit_y_in) * WPR + int'(edit_x_in) / WORD_SIZE) % NWORDS;
        ed_mask      = 32'h1 << (WORD_SIZE - 1 - int'(edit_x_in) % WORD_SIZE);
        edit_pending = 1'b1;
      end

      if (rnd_req_in) begin
        exp_q.push_back('{is_eng: 1'b0, data: shadow[rnd_addr_in], due: cyc + RD_LAT});
      end else if (eng_req_in && eng_gnt_out) begin
        if (eng_we_in) shadow[eng_addr_in] = eng_data_in;
        else exp_q.push_back('{is_eng: 1'b1, data: shadow[eng_addr_in], due: cyc + RD_LAT});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_130mhz);
      #1;
    end
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = LOG_MAX_ADDR'(a);
    pl_data = d;
    tick(1);
    pl_en   = 1'b0;
  endtask

  task automatic pulse_toggle(input int x, input int y);
    edit_x_in      = LOG_BOARD_SIZE'(x);
    edit_y_in      = LOG_BOARD_SIZE'(y);
    edit_toggle_in = 1'b1;
    tick(1);
    edit_toggle_in = 1'b0;
  endtask

  task automatic wait_edit_done(input string tag);
    int n = 0;
    while (edit_busy_out && n < 64) begin
      tick(1);
      n++;
    end
    check_eq(tag, 32'(edit_busy_out), 32'd0);
  endtask

  int b_wr, b_busy, b_xfer, b_bx, b_rv, b_ev;

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_rnd_valid", 32'(rnd_valid_out), 0);
    check_eq("rst_eng_valid", 32'(eng_valid_out), 0);
    check_eq("rst_eng_gnt",   32'(eng_gnt_out), 0);
    check_eq("rst_rd_data",   rd_data_out, 0);
    check_eq("rst_busy",      32'(edit_busy_out), 0);
    check_eq("rst_mem_addr",  32'(mem_addr_out), 0);
    check_eq("rst_mem_we",    32'(mem_we_out), 0);
    check_eq("rst_mem_din",   mem_din_out, 0);

    for (int a = 0; a < NWORDS; a++) preload(a, 32'(a));

    // Renderer stream 0..99 with the engine asking the whole time.
    rst_n = 1'b1;
    b_rv = rvalid_cnt; b_xfer = eng_xfer_cnt;
    eng_req_in = 1'b1; eng_we_in = 1'b0; eng_addr_in = '0;
    for (int i = 0; i < 100; i++) begin
      rnd_req_in  = 1'b1;
      rnd_addr_in = LOG_MAX_ADDR'(i);
      tick(1);
    end
    rnd_req_in = 1'b0; eng_req_in = 1'b0;
    tick(6);
    check_eq("rnd_stream_count", 32'(rvalid_cnt - b_rv), 32'd100);
    check_eq("rnd_stream_eng_xfers", 32'(eng_xfer_cnt - b_xfer), 32'd0);

    // Engine alone: read, write, read back.
    preload(7, 32'hDEADBEEF);
    eng_req_in = 1'b1; eng_we_in = 1'b0; eng_addr_in = 7'd7;
    #1;
    check_eq("eng_gnt_same_cycle", 32'(eng_gnt_out), 32'd1);
    tick(1);
    eng_req_in = 1'b0;
    tick(5);
    check_eq("eng_read_data", last_eng_data, 32'hDEADBEEF);
    eng_req_in = 1'b1; eng_we_in = 1'b1; eng_data_in = 32'h1234;
    tick(1);
    eng_we_in = 1'b0;
    tick(1);
    eng_req_in = 1'b0;
    tick(5);
    check_eq("eng_readback", last_eng_data, 32'h1234);

    // Toggle (5,2) on a zero word, then toggle back.
    preload(4, 32'h0);
    b_wr = wr_cnt; b_busy = busy_cycles;
    pulse_toggle(5, 2);
    check_eq("busy_after_pulse", 32'(edit_busy_out), 32'd1);
    wait_edit_done("toggle1_done");
    check_eq("toggle1_we", 32'(mem_we_out), 32'd1);
    check_eq("toggle1_addr", 32'(mem_addr_out), 32'(2 * WPR));
    check_eq("toggle1_din", mem_din_out, 32'h04000000);
    tick(3);
    check_eq("toggle1_writes", 32'(wr_cnt - b_wr), 32'd1);
    check_eq("toggle1_busy_len", 32'(busy_cycles - b_busy), 32'd5);
    check_eq("toggle1_mem", mem[4], 32'h04000000);
    pulse_toggle(5, 2);
    wait_edit_done("toggle2_done");
    tick(3);
    check_eq("toggle2_mem", mem[4], 32'h0);

    // Second pulse while busy is dropped.
    b_wr = wr_cnt;
    pulse_toggle(0, 1);
    pulse_toggle(40, 3);
    wait_edit_done("ignore_done");
    tick(3);
    check_eq("ignore_writes", 32'(wr_cnt - b_wr), 32'd1);
    check_eq("ignore_mem2", mem[2], 32'h80000002);
    check_eq("ignore_mem7", mem[7], 32'h1234);

    // Engine requesting continuously while the editor runs.
    b_bx = eng_busy_xfer; b_busy = busy_cycles;
    eng_req_in = 1'b1; eng_we_in = 1'b0; eng_addr_in = 7'd10;
    pulse_toggle(33, 5);
    wait_edit_done("contend_done");
    eng_req_in = 1'b0;
    tick(5);
    check_eq("contend_eng_during_edit_le1", 32'(eng_busy_xfer - b_bx <= 1), 32'd1);
    check_eq("contend_busy_le6", 32'(busy_cycles - b_busy <= 6), 32'd1);
    check_eq("contend_mem", mem[11], 32'h4000000B);

    // Reset while the editor waits for its read data.
    pulse_toggle(1, 0);
    tick(1);
    rst_n = 1'b0;
    #1;
    check_eq("rmw_rst_rnd_valid", 32'(rnd_valid_out), 0);
    check_eq("rmw_rst_eng_valid", 32'(eng_valid_out), 0);
    check_eq("rmw_rst_eng_gnt",   32'(eng_gnt_out), 0);
    check_eq("rmw_rst_rd_data",   rd_data_out, 0);
    check_eq("rmw_rst_busy",      32'(edit_busy_out), 0);
    check_eq("rmw_rst_mem_addr",  32'(mem_addr_out), 0);
    check_eq("rmw_rst_mem_we",    32'(mem_we_out), 0);
    check_eq("rmw_rst_mem_din",   mem_din_out, 0);
    tick(2);
    rst_n = 1'b1;
    b_wr = wr_cnt; b_rv = rvalid_cnt; b_ev = evalid_cnt;
    tick(10);
    check_eq("rmw_rst_writes", 32'(wr_cnt - b_wr), 0);
    check_eq("rmw_rst_strobes", 32'((rvalid_cnt - b_rv) + (evalid_cnt - b_ev)), 0);
    check_eq("rmw_rst_busy_after", 32'(edit_busy_out), 0);
    check_eq("rmw_rst_mem", mem[0], 32'h0);

    // Randomized mix of all three requesters.
    for (int i = 0; i < 3000; i++) begin
      rnd_req_in     = ($urandom_range(0, 99) < 30);
      rnd_addr_in    = LOG_MAX_ADDR'($urandom_range(0, NWORDS - 1));
      eng_req_in     = ($urandom_range(0, 99) < 50);
      eng_we_in      = ($urandom_range(0, 99) < 30);
      eng_addr_in    = LOG_MAX_ADDR'($urandom_range(0, NWORDS - 1));
      eng_data_in    = $urandom;
      edit_toggle_in = ($urandom_range(0, 99) < 3);
      edit_x_in      = LOG_BOARD_SIZE'($urandom_range(0, BOARD_SIZE - 1));
      edit_y_in      = LOG_BOARD_SIZE'($urandom_range(0, BOARD_SIZE - 1));
      tick(1);
    end
    rnd_req_in = 1'b0; eng_req_in = 1'b0; eng_we_in = 1'b0; edit_toggle_in = 1'b0;
    tick(5);
    wait_edit_done("random_edit_done");
    tick(5);
    for (int a = 0; a < NWORDS; a++) check_eq($sformatf("final_mem[%0d]", a), mem[a], shadow[a]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
